// File: rtl/obstacle_pkg.sv
// Shared constants and scanner state encoding for the obstacle collision scanner.
package obstacle_pkg;

  localparam int unsigned N_OBS_DEF = 6;
  localparam int unsigned X_W_DEF   = 8;
  localparam int unsigned Y_W_DEF   = 10;
  localparam int unsigned CAR_W_DEF = 16;
  localparam int unsigned CAR_H_DEF = 32;
  localparam int unsigned IDX_W     = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_e;

endpackage

// File: rtl/obstacle_overlap.sv
// Combinational bounding-box overlap test between one obstacle slot and the player car.
module obstacle_overlap #(
  parameter int unsigned X_W   = 8,
  parameter int unsigned Y_W   = 10,
  parameter int unsigned CAR_W = 16,
  parameter int unsigned CAR_H = 32
) (
  input  logic           on_i,
  input  logic [X_W-1:0] ox_i,
  input  logic [Y_W-1:0] oy_i,
  input  logic [X_W-1:0] px_i,
  input  logic [Y_W-1:0] py_i,
  output logic           hit_o
);

  localparam logic [X_W:0] THR_X = (X_W+1)'(CAR_W);
  localparam logic [Y_W:0] THR_Y = (Y_W+1)'(CAR_H);

  logic [X_W:0] dx;
  logic [Y_W:0] dy;

  // Subtract the smaller operand from the larger so the distance never wraps.
  always_comb begin
    dx = (ox_i >= px_i) ? ({1'b0, ox_i} - {1'b0, px_i}) : ({1'b0, px_i} - {1'b0, ox_i});
    dy = (oy_i >= py_i) ? ({1'b0, oy_i} - {1'b0, py_i}) : ({1'b0, py_i} - {1'b0, oy_i});
    hit_o = on_i && (dx < THR_X) && (dy < THR_Y);
  end

endmodule

// File: rtl/obstacle_collision_scanner.sv
// Per-frame sequential collision scan: one obstacle slot per clock against a snapshot
// of the obstacle table and player position.
import obstacle_pkg::*;

module obstacle_collision_scanner #(
  parameter int unsigned N_OBS = N_OBS_DEF,
  parameter int unsigned X_W   = X_W_DEF,
  parameter int unsigned Y_W   = Y_W_DEF,
  parameter int unsigned CAR_W = CAR_W_DEF,
  parameter int unsigned CAR_H = CAR_H_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [N_OBS-1:0]     obstacle_on,
  input  logic [N_OBS*X_W-1:0] obstacle_x,
  input  logic [N_OBS*Y_W-1:0] obstacle_y,
  input  logic [X_W-1:0]       player_x,
  input  logic [Y_W-1:0]       player_y,
  output logic                 busy,
  output logic                 done,
  output logic                 crash,
  output logic [IDX_W-1:0]     crash_idx,
  output logic [N_OBS-1:0]     crash_mask
);

  scan_state_e          state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [N_OBS-1:0]     mask_q, mask_d, mask_next;
  logic [N_OBS-1:0]     on_q, on_d;
  logic [N_OBS*X_W-1:0] ox_q, ox_d;
  logic [N_OBS*Y_W-1:0] oy_q, oy_d;
  logic [X_W-1:0]       px_q, px_d;
  logic [Y_W-1:0]       py_q, py_d;
  logic                 busy_d, done_d, crash_d;
  logic [IDX_W-1:0]     crash_idx_d, low_idx;
  logic [N_OBS-1:0]     crash_mask_d;
  logic                 hit;

  obstacle_overlap #(
    .X_W  (X_W),
    .Y_W  (Y_W),
    .CAR_W(CAR_W),
    .CAR_H(CAR_H)
  ) u_overlap (
    .on_i (on_q[idx_q]),
    .ox_i (ox_q[idx_q*X_W +: X_W]),
    .oy_i (oy_q[idx_q*Y_W +: Y_W]),
    .px_i (px_q),
    .py_i (py_q),
    .hit_o(hit)
  );

  // Mask including the slot under evaluation, and its lowest set bit.
  always_comb begin
    mask_next = mask_q | (N_OBS'(hit) << idx_q);
    low_idx   = '0;
    for (int i = int'(N_OBS) - 1; i >= 0; i--) begin
      if (mask_next[i]) low_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    mask_d       = mask_q;
    on_d         = on_q;
    ox_d         = ox_q;
    oy_d         = oy_q;
    px_d         = px_q;
    py_d         = py_q;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    crash_d      = 1'b0;
    crash_idx_d  = crash_idx;
    crash_mask_d = crash_mask;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          on_d    = obstacle_on;
          ox_d    = obstacle_x;
          oy_d    = obstacle_y;
          px_d    = player_x;
          py_d    = player_y;
          mask_d  = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      SCAN: begin
        mask_d = mask_next;
        idx_d  = idx_q + IDX_W'(1);
        busy_d = 1'b1;
        if (idx_q == IDX_W'(N_OBS - 1)) begin
          state_d      = DONE;
          idx_d        = '0;
          busy_d       = 1'b0;
          done_d       = 1'b1;
          crash_d      = |mask_next;
          crash_mask_d = mask_next;
          crash_idx_d  = low_idx;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      mask_q     <= '0;
      on_q       <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
      px_q       <= '0;
      py_q       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      crash      <= 1'b0;
      crash_idx  <= '0;
      crash_mask <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      mask_q     <= mask_d;
      on_q       <= on_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      px_q       <= px_d;
      py_q       <= py_d;
      busy       <= busy_d;
      done       <= done_d;
      crash      <= crash_d;
      crash_idx  <= crash_idx_d;
      crash_mask <= crash_mask_d;
    end
  end

endmodule

// File: tb/tb_obstacle_collision_scanner.sv
// Directed bench for obstacle_collision_scanner: latency, hit rule thresholds,
// start-while-busy, and mid-scan reset.
module tb_obstacle_collision_scanner;

  localparam int unsigned N_OBS = 6;
  localparam int unsigned X_W   = 8;
  localparam int unsigned Y_W   = 10;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic [N_OBS-1:0]     obstacle_on;
  logic [N_OBS*X_W-1:0] obstacle_x;
  logic [N_OBS*Y_W-1:0] obstacle_y;
  logic [X_W-1:0]       player_x;
  logic [Y_W-1:0]       player_y;
  logic                 busy, done, crash;
  logic [2:0]           crash_idx;
  logic [N_OBS-1:0]     crash_mask;

  int vectors = 0;
  int errors  = 0;
  int done_cnt;

  obstacle_collision_scanner dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .obstacle_on(obstacle_on),
    .obstacle_x (obstacle_x),
    .obstacle_y (obstacle_y),
    .player_x   (player_x),
    .player_y   (player_y),
    .busy       (busy),
    .done       (done),
    .crash      (crash),
    .crash_idx  (crash_idx),
    .crash_mask (crash_mask)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_slots();
    obstacle_on = '0;
    obstacle_x  = '0;
    obstacle_y  = '0;
  endtask

  task automatic set_slot(input int i, input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    obstacle_on[i]          = 1'b1;
    obstacle_x[i*X_W +: X_W] = x;
    obstacle_y[i*Y_W +: Y_W] = y;
  endtask

  // Start in cycle k, check busy k+1..k+6, done and results in k+7, pulse gone in k+8.
  task automatic run_scan(input string tag, input logic exp_crash,
                          input logic [N_OBS-1:0] exp_mask, input logic [2:0] exp_idx);
    start = 1'b1;
    step();
    start = 1'b0;
    done_cnt = 0;
    for (int c = 1; c <= 6; c++) begin
      if (done) done_cnt++;
      chk({tag, ".busy"}, 32'(busy), 32'd1);
      step();
    end
    chk({tag, ".done"},  32'(done), 32'd1);
    chk({tag, ".early_done"}, 32'(done_cnt), 32'd0);
    chk({tag, ".busy_off"}, 32'(busy), 32'd0);
    chk({tag, ".crash"}, 32'(crash), 32'(exp_crash));
    chk({tag, ".mask"},  32'(crash_mask), 32'(exp_mask));
    chk({tag, ".idx"},   32'(crash_idx), 32'(exp_idx));
    step();
    chk({tag, ".done_pulse"},  32'(done), 32'd0);
    chk({tag, ".crash_pulse"}, 32'(crash), 32'd0);
    chk({tag, ".mask_hold"},   32'(crash_mask), 32'(exp_mask));
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    clear_slots();
    player_x = '0;
    player_y = '0;
    step();
    step();
    reset = 1'b0;

    // Idle for 20 cycles: nothing moves.
    done_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (done || busy || crash) done_cnt++;
      step();
    end
    chk("idle.activity", 32'(done_cnt), 32'd0);
    chk("idle.mask", 32'(crash_mask), 32'd0);
    chk("idle.idx",  32'(crash_idx), 32'd0);

    run_scan("all_off", 1'b0, 6'b000000, 3'd0);

    player_x = 8'd100;
    player_y = 10'd400;
    clear_slots();
    set_slot(2, 8'd110, 10'd420);
    run_scan("slot2", 1'b1, 6'b000100, 3'd2);

    // dx=16 and dy=32 sit exactly on the thresholds; (15,31) is inside.
    clear_slots();
    set_slot(1, 8'd116, 10'd400);
    set_slot(3, 8'd100, 10'd432);
    set_slot(4, 8'd115, 10'd431);
    run_scan("threshold", 1'b1, 6'b010000, 3'd4);

    // Off slots never hit even on top of the player.
    clear_slots();
    obstacle_x[0 +: X_W] = 8'd100;
    obstacle_y[0 +: Y_W] = 10'd400;
    run_scan("off_overlap", 1'b0, 6'b000000, 3'd0);

    player_x = 8'd5;
    player_y = 10'd0;
    clear_slots();
    set_slot(0, 8'd250, 10'd0);
    run_scan("nowrap", 1'b0, 6'b000000, 3'd0);
    set_slot(0, 8'd0, 10'd20);
    run_scan("slot0", 1'b1, 6'b000001, 3'd0);

    // Inputs change and start re-asserts mid-scan: both ignored.
    player_x = 8'd100;
    player_y = 10'd400;
    clear_slots();
    set_slot(1, 8'd100, 10'd400);
    set_slot(5, 8'd90, 10'd380);
    start = 1'b1;
    step();
    start = 1'b0;
    done_cnt = 0;
    step();
    step();
    obstacle_x = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    chk("restart.done", 32'(done), 32'd1);
    chk("restart.crash", 32'(crash), 32'd1);
    chk("restart.mask", 32'(crash_mask), 32'h22);
    chk("restart.idx",  32'(crash_idx), 32'd1);
    step();
    for (int c = 0; c < 12; c++) begin
      if (done || busy) done_cnt++;
      step();
    end
    chk("restart.single_done", 32'(done_cnt), 32'd0);
    chk("restart.mask_hold", 32'(crash_mask), 32'h22);
    chk("restart.idx_hold",  32'(crash_idx), 32'd1);

    // Reset asserted in cycle k+3 aborts the scan.
    set_slot(1, 8'd100, 10'd400);
    set_slot(5, 8'd90, 10'd380);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.done", 32'(done), 32'd0);
    chk("abort.mask", 32'(crash_mask), 32'd0);
    chk("abort.idx",  32'(crash_idx), 32'd0);
    done_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (done || busy) done_cnt++;
      step();
    end
    chk("abort.quiet", 32'(done_cnt), 32'd0);

    run_scan("after_abort", 1'b1, 6'b100010, 3'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/obstacle_collision_scanner.md
Name: obstacle_collision_scanner

Overview:
- Reads the obstacle table that the obstacle spawner writes (per-slot on/x/y vectors) and checks every live obstacle against the player car's bounding box.
- Runs one scan per frame tick; reports crash status, lowest hit slot index and a full hit mask to the game controller.
- Sequential scanner: one slot per clock. No parallel comparator array.

Parameters:
- N_OBS, 6, number of obstacle slots
- X_W, 8, x-coordinate width
- Y_W, 10, y-coordinate width
- CAR_W, 16, car width in pixels; x-overlap threshold
- CAR_H, 32, car height in pixels; y-overlap threshold

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle scan request (frame tick)
- obstacle_on  in  N_OBS  per-slot live flag
- obstacle_x  in  N_OBS*X_W  slot i at bits [i*X_W +: X_W]
- obstacle_y  in  N_OBS*Y_W  slot i at bits [i*Y_W +: Y_W]
- player_x  in  X_W  player car x
- player_y  in  Y_W  player car y
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when the scan completes
- crash  out  1  one-cycle pulse, coincident with done, when any slot hit
- crash_idx  out  3  lowest hit slot index; held until the next done
- crash_mask  out  N_OBS  all hit slots; held until the next done

Behaviour:
- Interface is fixed: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values: busy=0, done=0, crash=0, crash_idx=0, crash_mask=0, state=IDLE, idx=0.
- FSM states and transitions:
  - IDLE: waiting for start.
  - IDLE -> SCAN: on a clock edge with start=1.
    - On that same edge, snapshot obstacle_on, obstacle_x, obstacle_y, player_x and player_y into internal registers.
    - Clear the accumulated mask; set idx=0.
  - SCAN: each edge evaluates slot idx from the snapshot and ORs the result into the accumulated mask at bit idx, then increments idx.
  - SCAN -> DONE: after idx=N_OBS-1 is evaluated.
  - DONE (one cycle): done=1; crash=|mask; crash_mask=mask; crash_idx=lowest set bit of mask, or 0 if mask is empty. Then -> IDLE.
- Latency: start sampled high in cycle k -> done high in cycle k+N_OBS+1 (cycle k+7 at default). busy is high in cycles k+1 through k+N_OBS.
- Hit rule for slot i: on_i=1 AND |ox_i - px| < CAR_W AND |oy_i - py| < CAR_H.
  - Differences are computed at X_W+1 / Y_W+1 bits, unsigned-extended, so no modular wrap.
  - Absolute value is taken by comparing operands, not by sign-flipping a wrapped result.
  - Equality with the threshold is NOT a hit (strict less-than).
- Slots with on=0 never hit, whatever their coordinates.
- start while busy or in DONE: ignored; no queuing, no restart.
- Input changes during a scan have no effect, because all comparisons use the snapshot.
- reset mid-scan: next state IDLE. All outputs return to their reset values; no done pulse for the aborted scan.
- crash_idx and crash_mask hold their values through IDLE until the next DONE overwrites them.

Decomposition:
- Shared package obstacle_pkg:
  - N_OBS, X_W, Y_W, CAR_W, CAR_H defaults.
  - Slot-index width constant (3).
  - Scanner state encoding: IDLE, SCAN, DONE.
- Sub-module obstacle_overlap:
  - Purely combinational.
  - Inputs: on, ox, oy, px, py. Output: hit.
  - Instantiated once and muxed by idx.
  - The collision renderer will reuse it.

Test Plan:
- Reset, no start for 20 cycles -> all outputs 0. Then start with all obstacle_on=0 -> done in cycle k+7, crash=0, crash_mask=0, crash_idx=0.
- player=(100,400); slot2 on at (110,420); others off -> crash=1 with done, crash_mask=6'b000100, crash_idx=2.
- player=(100,400); slot1 at (116,400), slot3 at (100,432), slot4 at (115,431), all on -> crash_mask=6'b010000, crash_idx=4 (exact threshold is not a hit).
- player_x=5, player_y=0; slot0 at (250,0) on -> no hit (widened diff 245), crash=0. Slot0 at (0,20) -> hit, crash_idx=0.
- Slots 1 and 5 both hit; change obstacle_x and assert start again 3 cycles into the scan -> crash_mask=6'b100010, crash_idx=1, exactly one done pulse, second start ignored.
- Start, assert reset in cycle k+3 -> busy=0 next cycle, no done pulse. A fresh start afterwards gives a done pulse 7 cycles later with correct results.
